// File: rtl/catapult_shim_pkg.sv
// catapult_shim_pkg: shared constants and types for the PCIe command shim.
//   - Command opcodes carried in bits [1:0] of a command word.
//   - Register map addresses for the counter block.
//   - FSM state encoding used by the top level.
package catapult_shim_pkg;

    // Command opcodes; 2 and 3 are NOPs.
    localparam logic [1:0] OP_WRITE = 2'd0;
    localparam logic [1:0] OP_READ  = 2'd1;

    // Bit position of the register address inside a command word.
    localparam int unsigned ADDR_LSB = 8;

    // Register map.
    localparam int unsigned ADDR_STEP     = 0;
    localparam int unsigned ADDR_DONE     = 1;
    localparam int unsigned ADDR_CYCLE    = 2;
    localparam int unsigned ADDR_SCRATCH0 = 3;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StWdata = 2'd1,
        StRresp = 2'd2
    } state_e;

endpackage

// File: rtl/catapult_shim_regs.sv
// catapult_shim_regs: host-visible register bank with the step/cycle counters.
//   clock, reset        : rising-edge clock, synchronous active-high reset
//   i_wr_en/addr/data   : write port, takes effect on the rising edge
//   i_rd_addr           : read address
//   o_rd_data           : combinational read of the pre-edge register contents
module catapult_shim_regs #(
    parameter int unsigned PCIE_WIDTH = 64,
    parameter int unsigned NUM_REGS   = 16,
    parameter int unsigned AW         = $clog2(NUM_REGS)
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  i_wr_en,
    input  logic [AW-1:0]         i_wr_addr,
    input  logic [PCIE_WIDTH-1:0] i_wr_data,
    input  logic [AW-1:0]         i_rd_addr,
    output logic [PCIE_WIDTH-1:0] o_rd_data
);
    import catapult_shim_pkg::*;

    logic [PCIE_WIDTH-1:0] r_step;
    logic [PCIE_WIDTH-1:0] r_cycle;
    logic [PCIE_WIDTH-1:0] r_scratch [NUM_REGS];

    logic w_step_wr;
    logic w_step_busy;
    logic w_scratch_wr;

    assign w_step_wr    = i_wr_en && (i_wr_addr == AW'(ADDR_STEP));
    assign w_scratch_wr = i_wr_en && (i_wr_addr >= AW'(ADDR_SCRATCH0));
    assign w_step_busy  = (r_step != '0);

    // A STEP write overrides the decrement; CYCLE counts off the pre-write value.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_step  <= '0;
            r_cycle <= '0;
        end else begin
            if (w_step_wr) begin
                r_step <= i_wr_data;
            end else if (w_step_busy) begin
                r_step <= r_step - PCIE_WIDTH'(1);
            end
            if (w_step_busy) begin
                r_cycle <= r_cycle + PCIE_WIDTH'(1);
            end
        end
    end

    // Entries below ADDR_SCRATCH0 are never written and read back as zero-reset storage
    // that the read mux shadows with the counter views.
    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < int'(NUM_REGS); i++) begin
                r_scratch[i] <= '0;
            end
        end else if (w_scratch_wr) begin
            r_scratch[i_wr_addr] <= i_wr_data;
        end
    end

    always_comb begin
        o_rd_data = r_scratch[i_rd_addr];
        if (i_rd_addr == AW'(ADDR_STEP)) begin
            o_rd_data = r_step;
        end else if (i_rd_addr == AW'(ADDR_DONE)) begin
            o_rd_data = {{(PCIE_WIDTH-1){1'b0}}, ~w_step_busy};
        end else if (i_rd_addr == AW'(ADDR_CYCLE)) begin
            o_rd_data = r_cycle;
        end
    end

endmodule

// File: rtl/catapult_shim.sv
// catapult_shim: single-outstanding-transaction command shim between a PCIe
// word stream and a small register bank.
//   clock, reset                 : rising-edge clock, synchronous active-high reset
//   io_pcie_in_valid/ready/bits  : host-to-shim command and write-data words
//   io_pcie_out_valid/ready/bits : shim-to-host read responses
// Command word: bits[1:0] opcode, bits[8 +: log2(NUM_REGS)] register address.
module catapult_shim #(
    parameter int unsigned PCIE_WIDTH = 64,
    parameter int unsigned NUM_REGS   = 16
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  io_pcie_in_valid,
    output logic                  io_pcie_in_ready,
    input  logic [PCIE_WIDTH-1:0] io_pcie_in_bits,
    output logic                  io_pcie_out_valid,
    input  logic                  io_pcie_out_ready,
    output logic [PCIE_WIDTH-1:0] io_pcie_out_bits
);
    import catapult_shim_pkg::*;

    localparam int unsigned AW = $clog2(NUM_REGS);

    state_e                r_state;
    state_e                w_state_d;
    logic [AW-1:0]         r_addr;
    logic [PCIE_WIDTH-1:0] r_out_bits;

    logic [1:0]            w_opcode;
    logic [AW-1:0]         w_cmd_addr;
    logic                  w_in_fire;
    logic                  w_out_fire;
    logic                  w_addr_load;
    logic                  w_out_load;
    logic                  w_wr_en;
    logic [PCIE_WIDTH-1:0] w_rd_data;

    assign w_opcode   = io_pcie_in_bits[1:0];
    assign w_cmd_addr = io_pcie_in_bits[ADDR_LSB +: AW];

    // Handshake outputs come from registered state only, forced low during reset.
    assign io_pcie_in_ready  = !reset && (r_state != StRresp);
    assign io_pcie_out_valid = !reset && (r_state == StRresp);
    assign io_pcie_out_bits  = r_out_bits;

    assign w_in_fire  = io_pcie_in_valid && io_pcie_in_ready;
    assign w_out_fire = io_pcie_out_valid && io_pcie_out_ready;

    catapult_shim_regs #(
        .PCIE_WIDTH (PCIE_WIDTH),
        .NUM_REGS   (NUM_REGS),
        .AW         (AW)
    ) u_regs (
        .clock      (clock),
        .reset      (reset),
        .i_wr_en    (w_wr_en),
        .i_wr_addr  (r_addr),
        .i_wr_data  (io_pcie_in_bits),
        .i_rd_addr  (w_cmd_addr),
        .o_rd_data  (w_rd_data)
    );

    always_comb begin
        w_state_d   = r_state;
        w_addr_load = 1'b0;
        w_out_load  = 1'b0;
        w_wr_en     = 1'b0;
        unique case (r_state)
            StIdle: begin
                if (w_in_fire) begin
                    if (w_opcode == OP_WRITE) begin
                        w_state_d   = StWdata;
                        w_addr_load = 1'b1;
                    end else if (w_opcode == OP_READ) begin
                        w_state_d  = StRresp;
                        w_out_load = 1'b1;
                    end
                end
            end
            StWdata: begin
                // The data word goes straight to the bank; it is never decoded.
                if (w_in_fire) begin
                    w_wr_en   = 1'b1;
                    w_state_d = StIdle;
                end
            end
            StRresp: begin
                if (w_out_fire) begin
                    w_state_d = StIdle;
                end
            end
            default: w_state_d = StIdle;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state    <= StIdle;
            r_addr     <= '0;
            r_out_bits <= '0;
        end else begin
            r_state <= w_state_d;
            if (w_addr_load) begin
                r_addr <= w_cmd_addr;
            end
            if (w_out_load) begin
                r_out_bits <= w_rd_data;
            end
        end
    end

endmodule

// File: tb/tb_catapult_shim.sv
module tb_catapult_shim;
    localparam int unsigned W  = 64;
    localparam int unsigned NR = 16;

    logic          clock     = 1'b0;
    logic          reset     = 1'b1;
    logic          in_valid  = 1'b0;
    logic          out_ready = 1'b0;
    logic [W-1:0]  in_bits   = '0;
    logic          in_ready;
    logic          out_valid;
    logic [W-1:0]  out_bits;

    catapult_shim #(
        .PCIE_WIDTH (W),
        .NUM_REGS   (NR)
    ) dut (
        .clock             (clock),
        .reset             (reset),
        .io_pcie_in_valid  (in_valid),
        .io_pcie_in_ready  (in_ready),
        .io_pcie_in_bits   (in_bits),
        .io_pcie_out_valid (out_valid),
        .io_pcie_out_ready (out_ready),
        .io_pcie_out_bits  (out_bits)
    );

    always #5 clock = ~clock;

    int              n_checks = 0;
    int              n_errors = 0;
    longint unsigned edge_cnt = 0;
    int              n_in     = 0;
    int              n_out    = 0;
    int              n_sent   = 0;
    int              n_recv   = 0;

    // Reference model: the last STEP write (value, edge) determines STEP and CYCLE
    // at any later edge arithmetically; scratch registers are a plain array.
    logic [63:0]     m_scratch [NR];
    logic [63:0]     m_n;
    logic [63:0]     m_base;
    longint unsigned m_ew;

    always @(posedge clock) begin
        edge_cnt++;
        if (in_valid && in_ready) n_in++;
        if (out_valid && out_ready) n_out++;
    end

    function automatic logic [63:0] step_at(input longint unsigned e);
        logic [63:0] k;
        k = 64'(e - m_ew);
        return (m_n > k) ? (m_n - k) : 64'd0;
    endfunction

    function automatic logic [63:0] cycle_at(input longint unsigned e);
        logic [63:0] k;
        k = 64'(e - m_ew);
        return (k < m_n) ? (m_base + k) : (m_base + m_n);
    endfunction

    // Value registered after edge e.
    function automatic logic [63:0] model_read(input int a, input longint unsigned e);
        case (a)
            0:       return step_at(e);
            1:       return (step_at(e) == 64'd0) ? 64'd1 : 64'd0;
            2:       return cycle_at(e);
            default: return m_scratch[a];
        endcase
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clock);
        #1;
    endtask

    function automatic logic [63:0] make_cmd(input logic [1:0] op, input int a);
        logic [63:0] w;
        w       = {$urandom, $urandom};
        w[1:0]  = op;
        w[11:8] = 4'(a);
        return w;
    endfunction

    // Offer one word and return the edge on which it transferred.
    task automatic send(input logic [63:0] w, output longint unsigned e);
        int t;
        t        = 0;
        in_valid = 1'b1;
        in_bits  = w;
        while (in_ready !== 1'b1 && t < 100) begin
            tick;
            t++;
        end
        if (t >= 100) check("in_ready_timeout", 64'd0, 64'd1);
        tick;
        e        = edge_cnt;
        n_sent++;
        in_valid = 1'b0;
        in_bits  = {$urandom, $urandom};
    endtask

    task automatic do_reset;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        reset     = 1'b1;
        tick;
        check("rst_in_ready", 64'(in_ready), 64'd0);
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_out_bits", out_bits, 64'd0);
        tick;
        reset  = 1'b0;
        m_n    = 64'd0;
        m_base = 64'd0;
        m_ew   = edge_cnt;
        for (int i = 0; i < int'(NR); i++) m_scratch[i] = 64'd0;
        tick;
        check("post_rst_in_ready", 64'(in_ready), 64'd1);
    endtask

    task automatic do_write(input int a, input logic [63:0] data, input int gap);
        longint unsigned e;
        logic [63:0]     pre_s;
        repeat (gap) tick;
        send(make_cmd(2'd0, a), e);
        repeat (gap) tick;
        send(data, e);
        if (a == 0) begin
            pre_s  = step_at(e - 1);
            m_base = cycle_at(e - 1) + ((pre_s != 64'd0) ? 64'd1 : 64'd0);
            m_n    = data;
            m_ew   = e;
        end else if (a >= 3) begin
            m_scratch[a] = data;
        end
    endtask

    task automatic do_read(input int a, input int gap, input int hold, output logic [63:0] data);
        longint unsigned e;
        logic [63:0]     first;
        repeat (gap) tick;
        send(make_cmd(2'd1, a), e);
        check("rd_out_valid_latency", 64'(out_valid), 64'd1);
        check("rd_in_ready_low", 64'(in_ready), 64'd0);
        first = out_bits;
        for (int h = 0; h < hold; h++) begin
            tick;
            check("rd_hold_valid", 64'(out_valid), 64'd1);
            check("rd_hold_stable", out_bits, first);
            check("rd_hold_in_ready", 64'(in_ready), 64'd0);
        end
        out_ready = 1'b1;
        tick;
        out_ready = 1'b0;
        n_recv++;
        check("rd_out_valid_drop", 64'(out_valid), 64'd0);
        check("rd_data", first, model_read(a, e - 1));
        data = first;
    endtask

    task automatic do_nop(input int gap);
        longint unsigned e;
        repeat (gap) tick;
        send(make_cmd(2'(2 + $urandom_range(0, 1)), $urandom_range(0, 15)), e);
        check("nop_no_resp", 64'(out_valid), 64'd0);
        check("nop_in_ready", 64'(in_ready), 64'd1);
    endtask

    initial begin
        logic [63:0] rd;
        int          op;
        int          a;
        int          gap;
        int          outs;

        do_reset();

        // Write then read back a scratch register.
        do_write(5, 64'hDEADBEEF, 0);
        do_read(5, 0, 0, rd);
        check("scratch5_const", rd, 64'hDEADBEEF);

        // STEP=3: DONE low immediately, then CYCLE=3 and DONE=1 once it expires.
        do_write(0, 64'd3, 0);
        do_read(1, 0, 0, rd);
        check("done_busy_const", rd, 64'd0);
        repeat (4) tick;
        do_read(2, 0, 0, rd);
        check("cycle_const", rd, 64'd3);
        do_read(1, 0, 0, rd);
        check("done_idle_const", rd, 64'd1);

        // Back-pressured response held for 5 cycles, exactly one transfer.
        do_write(7, {$urandom, $urandom}, 1);
        outs = n_out;
        do_read(7, 0, 5, rd);
        check("bp_one_transfer", 64'(n_out - outs), 64'd1);

        // NOP then a write to read-only DONE.
        outs = n_out;
        do_nop(0);
        do_write(1, 64'd5, 0);
        check("nop_no_transfer", 64'(n_out), 64'(outs));
        do_read(1, 0, 0, rd);
        check("done_ro_const", rd, 64'd1);

        // Reset abandons a pending write.
        do_write(3, 64'h1234_5678, 0);
        begin
            longint unsigned e;
            send(make_cmd(2'd0, 3), e);
        end
        do_reset();
        do_read(3, 0, 0, rd);
        check("scratch3_after_rst", rd, 64'd0);

        // Randomised mixed traffic with valid/ready throttling.
        for (int i = 0; i < 1000; i++) begin
            op  = $urandom_range(0, 2);
            a   = ($urandom_range(0, 1) == 1) ? $urandom_range(0, 2) : $urandom_range(3, 15);
            gap = $urandom_range(0, 2);
            case (op)
                0: do_write(a, (a == 0) ? 64'($urandom_range(0, 20)) : {$urandom, $urandom},
                            gap);
                1: do_read(a, gap, $urandom_range(0, 3), rd);
                default: do_nop(gap);
            endcase
        end
        tick;
        check("in_transfer_count", 64'(n_in), 64'(n_sent));
        check("out_transfer_count", 64'(n_out), 64'(n_recv));

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/catapult_shim.md
CATAPULT_SHIM -- requirements
Module: catapult_shim

Interface
REQ-001 Parameter PCIE_WIDTH, 64, width of every PCIe word in both directions; legal values are 32 or larger.
REQ-002 Parameter NUM_REGS, 16, number of word-wide registers addressable by the host; must be a power of two.
REQ-003 Port clock, input, 1, the single clock; every flop samples on its rising edge.
REQ-004 Port reset, input, 1, reset; synchronous and active-high.
REQ-005 Port io_pcie_in_valid, input, 1, the host offers a word.
REQ-006 Port io_pcie_in_ready, output, 1, the shim accepts the offered word.
REQ-007 Port io_pcie_in_bits, input, PCIE_WIDTH, host-to-shim word.
REQ-008 Port io_pcie_out_valid, output, 1, the shim offers a response word.
REQ-009 Port io_pcie_out_ready, input, 1, the host accepts the response word.
REQ-010 Port io_pcie_out_bits, output, PCIE_WIDTH, shim-to-host word.

Function
REQ-011 Handshake: a word transfers on any clock edge where valid and ready are both 1; no other transfer occurs.
REQ-012 Command word fields: bits[1:0] opcode (0 WRITE, 1 READ, 2 and 3 NOP); bits[8+log2(NUM_REGS)-1:8] register address; all other bits ignored.
REQ-013 The shim has three states: IDLE, WDATA and RRESP.
REQ-014 Outputs by state: io_pcie_in_ready is 1 in IDLE and WDATA, 0 in RRESP; io_pcie_out_valid is 1 only in RRESP; both are decoded from registered state only.
REQ-015 IDLE transitions on a command transfer: WRITE goes to WDATA (address latched); READ goes to RRESP; NOP is consumed and stays in IDLE.
REQ-016 On a READ transfer, io_pcie_out_bits is loaded with the addressed register, so the response is valid one cycle after the command.
REQ-017 WDATA: the next transfer is the data word; the addressed register is written on that edge and the state returns to IDLE; the data word is never decoded as a command.
REQ-018 RRESP: io_pcie_out_bits stays stable while io_pcie_out_ready is 0; the state returns to IDLE on the out transfer.
REQ-019 Only one transaction is outstanding at a time, so input is back-pressured during RRESP.
REQ-020 Register map, address 0 STEP (R/W): a write of N loads the step counter; while it is nonzero it decrements by 1 every cycle; a read returns the current count.
REQ-021 Address 1 DONE (RO): reads 1 when the step counter is 0, else 0; writes are ignored.
REQ-022 Address 2 CYCLE (RO): PCIE_WIDTH-bit counter that increments on every cycle where the step counter is nonzero; wraps modulo 2^PCIE_WIDTH; writes are ignored.
REQ-023 Addresses 3 to NUM_REGS-1 are scratch registers: plain R/W storage with read-back equal to the last write.
REQ-024 Simultaneous events: a STEP write wins over the decrement in the same cycle, and a CYCLE increment occurs based on the pre-write count.
REQ-025 A READ of STEP, DONE or CYCLE returns the value registered before the edge on which the command transfers.

Reset
REQ-026 While reset is 1 at an edge: state goes to IDLE, all registers and counters clear to 0, and io_pcie_out_bits clears to 0.
REQ-027 During reset, io_pcie_in_ready and io_pcie_out_valid are 0 by gating with reset.
REQ-028 Reset mid-transaction abandons any pending WDATA or RRESP without producing a response.
REQ-029 The cycle after reset deasserts, io_pcie_in_ready is 1.

Structure
REQ-030 Package catapult_shim_pkg holds the opcode constants, the register address constants (STEP=0, DONE=1, CYCLE=2) and the state enum.
REQ-031 The register bank and the step/cycle counters form one sub-module, catapult_shim_regs, with a read port and a write port.
REQ-032 The top-level module holds only the FSM and the handshake logic.

Verification
REQ-033 WRITE addr 5 then data 0xDEADBEEF, then READ addr 5 -> one response of 0xDEADBEEF, with out_valid one cycle after the READ transfer.
REQ-034 WRITE STEP=3 -> CYCLE reads 3 and DONE reads 1 after 4 or more idle cycles; READ DONE issued immediately after the data word returns 0.
REQ-035 READ addr 7 with out_ready held 0 for 5 cycles -> out_valid stays 1, bits stay stable, in_ready stays 0, and exactly one transfer occurs when out_ready rises.
REQ-036 NOP command, then WRITE DONE=5 -> no response is produced and DONE still reads 1.
REQ-037 Reset asserted in WDATA after a WRITE addr 3 command, then READ addr 3 -> returns 0.
REQ-038 Randomised valid and ready throttling over 1000 mixed commands -> every read equals the scoreboard value and no transfers are lost or duplicated.
